// File: rtl/reg_file_pkg.sv
// Shared types and helpers for reg_file: clear FSM state encoding, byte-lane width
// and the byte-merge used by both the write path and the read bypass.
package reg_file_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // One byte lane of a strobed write: take the new byte when its strobe is set.
    function automatic logic [BYTE_W-1:0] merge_bytes(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              strb
    );
        return strb ? new_b : old_b;
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer for reg_file: on a clear request walks every entry address once,
// one per cycle, asserting a clear-write for each while busy is held high.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // Requests arriving while a sequence runs are ignored, not queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q == LastAddr) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file.sv
// DATA_W x DEPTH register file: one byte-strobed write port, two registered read ports
// and a hardware clear sequencer. Define REG_FILE_BYPASS_EN for write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned STRB_W = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr,
    output logic              busy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              waddr_ok;
    logic              wr_acc;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rdata_a_d, rdata_a_q;
    logic [DATA_W-1:0] rdata_b_d, rdata_b_q;

    reg_file_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (clr),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // A clear request wins over a same-cycle write, and a running clear blocks writes.
    always_comb begin
        waddr_ok = 32'(waddr) < DEPTH;
        wr_acc   = we & ~busy & ~clr & waddr_ok;
        wr_old   = waddr_ok ? mem_q[waddr] : '0;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            wr_merged[k*BYTE_W +: BYTE_W] = merge_bytes(wr_old[k*BYTE_W +: BYTE_W],
                                                        wdata[k*BYTE_W +: BYTE_W], wstrb[k]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clr_we && (32'(clr_addr) == i)) begin
                mem_d[i] = '0;
            end else if (wr_acc && (32'(waddr) == i)) begin
                mem_d[i] = wr_merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_a_d = (32'(raddr_a) < DEPTH) ? mem_q[raddr_a] : '0;
        rdata_b_d = (32'(raddr_b) < DEPTH) ? mem_q[raddr_b] : '0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_acc && (raddr_a == waddr)) begin
            rdata_a_d = wr_merged;
        end
        if (wr_acc && (raddr_b == waddr)) begin
            rdata_b_d = wr_merged;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file (DATA_W=16, DEPTH=4): expectations are queued as stimulus
// is driven and checked one cycle later. Honours REG_FILE_BYPASS_EN.
module tb_reg_file;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wstrb = '0;
    logic [1:0]  raddr_a = '0;
    logic [1:0]  raddr_b = '0;
    logic        clr = 1'b0;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef enum int {PortA, PortB, PortBusy} port_e;
    typedef struct {
        string       tag;
        port_e       port;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    reg_file #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b),
        .clr     (clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input port_e port, input logic [15:0] val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.port)
                PortA:   check(e.tag, rdata_a, e.val);
                PortB:   check(e.tag, rdata_b, e.val);
                default: check(e.tag, {15'b0, busy}, e.val);
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
        tick();
        we    = 1'b0;
        wstrb = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [1:0] b, input logic [15:0] ea,
                      input logic [15:0] eb, input string tag);
        raddr_a = a;
        raddr_b = b;
        push($sformatf("%s_a", tag), PortA, ea);
        push($sformatf("%s_b", tag), PortB, eb);
        tick();
    endtask

    initial begin
        // Reset state while rst is held
        #12;
        push("rst_busy", PortBusy, 16'h0);
        push("rst_rdata_a", PortA, 16'h0);
        push("rst_rdata_b", PortB, 16'h0);
        drain();
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rd(2'(i), 2'(3 - i), 16'h0, 16'h0, $sformatf("post_rst%0d", i));
        end
        push("post_rst_busy", PortBusy, 16'h0);
        tick();

        // Byte strobes
        wr(2'd1, 16'hAAAA, 2'b11);
        wr(2'd1, 16'h5555, 2'b01);
        rd(2'd1, 2'd1, 16'hAA55, 16'hAA55, "strobe");
        wr(2'd1, 16'h1234, 2'b00);
        rd(2'd1, 2'd1, 16'hAA55, 16'hAA55, "strobe_none");

        // Dual read
        wr(2'd0, 16'h0011, 2'b11);
        wr(2'd1, 16'h0022, 2'b11);
        wr(2'd2, 16'h0033, 2'b11);
        rd(2'd0, 2'd2, 16'h0011, 16'h0033, "dual");

        // Read during write to the same address
        raddr_a = 2'd1;
        raddr_b = 2'd2;
`ifdef REG_FILE_BYPASS_EN
        push("rdw_a", PortA, 16'h0044);
`else
        push("rdw_a", PortA, 16'h0022);
`endif
        push("rdw_b_other", PortB, 16'h0033);
        wr(2'd1, 16'h0044, 2'b11);
        rd(2'd1, 2'd1, 16'h0044, 16'h0044, "rdw_after");

        // Hardware clear with writes attempted while busy
        for (int i = 0; i < 4; i++) begin
            wr(2'(i), 16'hFFFF, 2'b11);
        end
        clr = 1'b1;
        we  = 1'b1;
        waddr = 2'd2;
        wdata = 16'h1234;
        wstrb = 2'b11;
        push("clr_busy_e0", PortBusy, 16'h1);
        tick();
        clr = 1'b0;
        waddr = 2'd3;
        wdata = 16'h0077;
        raddr_a = 2'd3;
        push("clr_busy_e1", PortBusy, 16'h1);
        push("clr_read_old", PortA, 16'hFFFF);
        tick();
        we = 1'b0;
        raddr_a = 2'd0;
        push("clr_busy_e2", PortBusy, 16'h1);
        push("clr_read_cleared", PortA, 16'h0000);
        tick();
        we = 1'b1;
        waddr = 2'd0;
        wdata = 16'h0077;
        push("clr_busy_e3", PortBusy, 16'h1);
        tick();
        we = 1'b0;
        push("clr_busy_e4", PortBusy, 16'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), 2'(i), 16'h0, 16'h0, $sformatf("clr_done%0d", i));
        end

        // Reset asserted two cycles into a clear
        wr(2'd3, 16'hBEEF, 2'b11);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        push("midclr_busy_before", PortBusy, 16'h1);
        drain();
        rst = 1'b1;
        #1;
        push("midclr_busy", PortBusy, 16'h0);
        push("midclr_rdata_a", PortA, 16'h0);
        drain();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("midclr_busy%0d", i), PortBusy, 16'h0);
            rd(2'(i), 2'(3 - i), 16'h0, 16'h0, $sformatf("midclr_zero%0d", i));
        end
        wr(2'd0, 16'h005A, 2'b11);
        rd(2'd0, 2'd0, 16'h005A, 16'h005A, "midclr_wr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
